// File: rtl/pwm_deadband_if.sv
// APB-style register port shared by the PWM generator and the dead-band stage.
// The master drives address/control/data; the slave returns read data and ready.
interface pwm_deadband_if;
    logic [31:0] apb_addr;
    logic        apb_sel;
    logic        apb_write;
    logic        apb_ena;
    logic [31:0] apb_wdata;
    logic [31:0] apb_rdata;
    logic [3:0]  apb_pstb;
    logic        apb_rready;

    modport master (
        output apb_addr, apb_sel, apb_write, apb_ena, apb_wdata, apb_pstb,
        input  apb_rdata, apb_rready
    );

    modport slave (
        input  apb_addr, apb_sel, apb_write, apb_ena, apb_wdata, apb_pstb,
        output apb_rdata, apb_rready
    );
endinterface

// File: rtl/pwm_deadband.sv
// Two-channel complementary gate driver with programmable rising/falling dead time
// and short-pulse swallowing. Define PWM_DB_GLITCH_CNT_EN to build the glitch counters.
module pwm_deadband #(
    parameter int DT_W = 16
) (
    input  logic           clock,
    input  logic           rstn,
    pwm_deadband_if.slave  apb,
    input  logic [1:0]     pwm_i,
    output logic [1:0]     pwm_hs_o,
    output logic [1:0]     pwm_ls_o
);
    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_LS_ON  = 3'd1,
        ST_DEAD_R = 3'd2,
        ST_HS_ON  = 3'd3,
        ST_DEAD_F = 3'd4
    } state_t;

    logic [3:0]      ctrl_reg;
    logic [DT_W-1:0] dt_reg [4];   // DT0R, DT0F, DT1R, DT1F
    logic [31:0]     rdata_reg;
    logic [31:0]     rd_val;
    logic [2:0]      st_val [2];
    logic [1:0]      glitch_inc;
    logic [7:0]      addr;
    logic            wr_en;
    logic            rd_en;
    logic            unused_apb;

    assign addr       = apb.apb_addr[7:0];
    assign wr_en      = apb.apb_sel && apb.apb_write && !apb.apb_ena;
    assign rd_en      = apb.apb_sel && !apb.apb_write && !apb.apb_ena;
    assign unused_apb = ^{apb.apb_addr[31:8], apb.apb_pstb, apb.apb_wdata};
    assign apb.apb_rready = 1'b1;
    assign apb.apb_rdata  = rdata_reg;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            ctrl_reg <= '0;
            for (int i = 0; i < 4; i++) dt_reg[i] <= '0;
        end else if (wr_en) begin
            case (addr)
                8'h00: ctrl_reg  <= apb.apb_wdata[3:0];
                8'h04: dt_reg[0] <= apb.apb_wdata[DT_W-1:0];
                8'h08: dt_reg[1] <= apb.apb_wdata[DT_W-1:0];
                8'h0C: dt_reg[2] <= apb.apb_wdata[DT_W-1:0];
                8'h10: dt_reg[3] <= apb.apb_wdata[DT_W-1:0];
                default: ;
            endcase
        end
    end

`ifdef PWM_DB_GLITCH_CNT_EN
    logic [15:0] glitch_reg [2];
    logic        glitch_clr;

    assign glitch_clr = wr_en && (addr == 8'h18);

    for (genvar gi = 0; gi < 2; gi++) begin : g_glitch
        // A clear on the same edge as a swallowed pulse wins over the increment.
        always_ff @(posedge clock or negedge rstn) begin
            if (!rstn)
                glitch_reg[gi] <= '0;
            else if (glitch_clr)
                glitch_reg[gi] <= '0;
            else if (glitch_inc[gi] && glitch_reg[gi] != 16'hFFFF)
                glitch_reg[gi] <= glitch_reg[gi] + 16'd1;
        end
    end
`else
    logic unused_glitch;
    assign unused_glitch = ^glitch_inc;
`endif

    always_comb begin
        rd_val = '0;
        case (addr)
            8'h00: rd_val = {28'd0, ctrl_reg};
            8'h04: rd_val = 32'(dt_reg[0]);
            8'h08: rd_val = 32'(dt_reg[1]);
            8'h0C: rd_val = 32'(dt_reg[2]);
            8'h10: rd_val = 32'(dt_reg[3]);
            8'h14: rd_val = {25'd0, st_val[1], 1'b0, st_val[0]};
`ifdef PWM_DB_GLITCH_CNT_EN
            8'h18: rd_val = {glitch_reg[1], glitch_reg[0]};
`endif
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn)
            rdata_reg <= '0;
        else if (rd_en)
            rdata_reg <= rd_val;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        state_t          state_reg, state_next;
        logic [DT_W-1:0] cnt_reg, cnt_next;
        logic [DT_W-1:0] dt_r, dt_f;
        logic            en, inv, hs_reg, ls_reg, glitch_hit;

        assign en   = ctrl_reg[gi];
        assign inv  = ctrl_reg[2+gi];
        assign dt_r = dt_reg[2*gi];
        assign dt_f = dt_reg[2*gi+1];

        always_ff @(posedge clock or negedge rstn) begin
            if (!rstn) begin
                state_reg <= ST_OFF;
                cnt_reg   <= '0;
                hs_reg    <= 1'b0;
                ls_reg    <= 1'b0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
                hs_reg    <= (state_next == ST_HS_ON) ^ inv;
                ls_reg    <= (state_next == ST_LS_ON) ^ inv;
            end
        end

        // Zero dead time skips the dead state so the sides swap with no gap.
        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            glitch_hit = 1'b0;
            if (!en) begin
                state_next = ST_OFF;
            end else begin
                case (state_reg)
                    ST_OFF, ST_HS_ON: begin
                        if (state_reg == ST_OFF || !pwm_i[gi]) begin
                            state_next = (dt_f == '0) ? ST_LS_ON : ST_DEAD_F;
                            cnt_next   = DT_W'(1);
                        end
                    end
                    ST_LS_ON: begin
                        if (pwm_i[gi]) begin
                            state_next = (dt_r == '0) ? ST_HS_ON : ST_DEAD_R;
                            cnt_next   = DT_W'(1);
                        end
                    end
                    ST_DEAD_R: begin
                        if (!pwm_i[gi]) begin
                            state_next = ST_LS_ON;
                            glitch_hit = 1'b1;
                        end else if (cnt_reg >= dt_r) begin
                            state_next = ST_HS_ON;
                        end else begin
                            cnt_next = cnt_reg + DT_W'(1);
                        end
                    end
                    ST_DEAD_F: begin
                        if (pwm_i[gi]) begin
                            state_next = ST_HS_ON;
                            glitch_hit = 1'b1;
                        end else if (cnt_reg >= dt_f) begin
                            state_next = ST_LS_ON;
                        end else begin
                            cnt_next = cnt_reg + DT_W'(1);
                        end
                    end
                    default: state_next = ST_OFF;
                endcase
            end
        end

        assign pwm_hs_o[gi]   = hs_reg;
        assign pwm_ls_o[gi]   = ls_reg;
        assign glitch_inc[gi] = glitch_hit;
        assign st_val[gi]     = state_reg;
    end
endmodule

// File: tb/tb_pwm_deadband.sv
// Randomised scoreboard bench for pwm_deadband: a driver feeds stimulus into a
// side-based behavioural model and queues expectations; a monitor checks them.
module tb_pwm_deadband;
    localparam int DT_W = 16;
    localparam int M_OFF = 0, M_ON = 1, M_DEAD = 2;

    logic       clock = 1'b0;
    logic       rstn  = 1'b0;
    logic [1:0] pwm_i = 2'b00;
    logic [1:0] pwm_hs_o, pwm_ls_o;

    pwm_deadband_if bus ();

    pwm_deadband #(.DT_W(DT_W)) dut (
        .clock    (clock),
        .rstn     (rstn),
        .apb      (bus),
        .pwm_i    (pwm_i),
        .pwm_hs_o (pwm_hs_o),
        .pwm_ls_o (pwm_ls_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        int          kind;   // 0 = gate outputs {hs,ls}, 1 = apb_rdata
        logic [31:0] exp;
        logic [7:0]  addr;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: each channel is either off, resting on a side, or in a
    // dead interval moving towards a side with an elapsed-cycle count.
    int m_ctrl;
    int m_dt[4];
    int m_mode[2];
    int m_side[2];
    int m_elapsed[2];
    int m_glitch[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_ctrl = 0;
        for (int i = 0; i < 4; i++) m_dt[i] = 0;
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = M_OFF; m_side[c] = 0; m_elapsed[c] = 0; m_glitch[c] = 0;
        end
    endtask

    function automatic int m_status(input int c);
        if (m_mode[c] == M_OFF) return 0;
        if (m_mode[c] == M_ON)  return (m_side[c] == 1) ? 3 : 1;
        return (m_side[c] == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h00: return 32'(m_ctrl);
            8'h04: return 32'(m_dt[0]);
            8'h08: return 32'(m_dt[1]);
            8'h0C: return 32'(m_dt[2]);
            8'h10: return 32'(m_dt[3]);
            8'h14: return 32'(m_status(0) + 16 * m_status(1));
`ifdef PWM_DB_GLITCH_CNT_EN
            8'h18: return 32'(m_glitch[0] + 65536 * m_glitch[1]);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_move(input int c, input int side);
        int dt;
        dt = (side == 1) ? m_dt[2*c] : m_dt[2*c+1];
        m_side[c] = side;
        if (dt == 0) m_mode[c] = M_ON;
        else begin m_mode[c] = M_DEAD; m_elapsed[c] = 1; end
    endtask

    task automatic m_step(input logic [1:0] p, input int op, input logic [7:0] a,
                          input logic [31:0] d, output logic [3:0] outs);
        logic [1:0] hs, ls;
        int hit[2];
        int dt, pc;
        for (int c = 0; c < 2; c++) begin
            hit[c] = 0;
            pc = int'(p[c]);
            if (m_ctrl[c] == 1'b0) m_mode[c] = M_OFF;
            else if (m_mode[c] == M_OFF) m_move(c, 0);
            else if (m_mode[c] == M_ON) begin
                if (pc != m_side[c]) m_move(c, pc);
            end else begin
                dt = (m_side[c] == 1) ? m_dt[2*c] : m_dt[2*c+1];
                if (pc != m_side[c]) begin
                    m_side[c] = 1 - m_side[c]; m_mode[c] = M_ON; hit[c] = 1;
                end else if (m_elapsed[c] >= dt) m_mode[c] = M_ON;
                else m_elapsed[c]++;
            end
            hs[c] = ((m_mode[c] == M_ON) && (m_side[c] == 1)) ^ m_ctrl[2+c];
            ls[c] = ((m_mode[c] == M_ON) && (m_side[c] == 0)) ^ m_ctrl[2+c];
        end
        outs = {hs, ls};
        for (int c = 0; c < 2; c++)
            if (hit[c] == 1 && m_glitch[c] < 65535) m_glitch[c]++;
        if (op == 1) begin
            case (a)
                8'h00: m_ctrl = int'(d[3:0]);
                8'h04: m_dt[0] = int'(d[DT_W-1:0]);
                8'h08: m_dt[1] = int'(d[DT_W-1:0]);
                8'h0C: m_dt[2] = int'(d[DT_W-1:0]);
                8'h10: m_dt[3] = int'(d[DT_W-1:0]);
                8'h18: begin m_glitch[0] = 0; m_glitch[1] = 0; end
                default: ;
            endcase
        end
    endtask

    // One clock of stimulus, issued just after a falling edge. op: 0 idle, 1 write, 2 read.
    task automatic cycle(input logic [1:0] p, input int op, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        logic [3:0] outs;
        pwm_i           = p;
        bus.apb_sel     = (op != 0);
        bus.apb_write   = (op == 1);
        bus.apb_ena     = 1'b0;
        bus.apb_addr    = {24'd0, a};
        bus.apb_wdata   = d;
        if (op == 2) begin
            e.cyc = cyc + 1; e.kind = 1; e.exp = m_read(a); e.addr = a;
            sb_q.push_back(e);
            $display("apb read  addr=0x%02h expect=0x%08h", a, e.exp);
        end else if (op == 1) begin
            $display("apb write addr=0x%02h data=0x%08h", a, d);
        end
        m_step(p, op, a, d, outs);
        e.cyc = cyc + 1; e.kind = 0; e.exp = {28'd0, outs}; e.addr = 8'h00;
        sb_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        bus.apb_sel = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [1:0] p);
        cycle(p, 1, a, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [1:0] p);
        cycle(p, 2, a, 32'd0);
    endtask

    task automatic idle(input logic [1:0] p, input int n);
        for (int i = 0; i < n; i++) cycle(p, 0, 8'h00, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                if (e.kind == 0)
                    chk("gate_outputs{hs,ls}", {28'd0, pwm_hs_o, pwm_ls_o}, e.exp);
                else
                    chk($sformatf("rdata_addr_%02h", e.addr), bus.apb_rdata, e.exp);
            end
        end
    end

    initial begin : driver
        int hold[2];
        logic [1:0] p;
        logic [7:0] rd_addrs[9];
        int r;
        rd_addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20};
        bus.apb_sel = 1'b0; bus.apb_write = 1'b0; bus.apb_ena = 1'b0;
        bus.apb_addr = '0; bus.apb_wdata = '0; bus.apb_pstb = 4'hF;
        m_reset();

        repeat (3) @(negedge clock);
        chk("reset_outputs", {28'd0, pwm_hs_o, pwm_ls_o}, 32'd0);
        chk("reset_rdata", bus.apb_rdata, 32'd0);
        chk("rready", {31'd0, bus.apb_rready}, 32'd1);
        rstn = 1'b1;
        for (int i = 0; i < 7; i++) rd(rd_addrs[i], 2'b00);

        // Basic dead-time timing on channel 0.
        wr(8'h04, 32'd3, 2'b00); wr(8'h08, 32'd2, 2'b00); wr(8'h00, 32'h1, 2'b00);
        idle(2'b00, 4); idle(2'b01, 6); idle(2'b00, 5);

        // Pulse shorter than the rising dead time is swallowed.
        wr(8'h04, 32'd5, 2'b00);
        idle(2'b01, 2); idle(2'b00, 3);
        rd(8'h18, 2'b00); wr(8'h18, 32'd0, 2'b00); rd(8'h18, 2'b00);

        // Zero dead time on channel 1: outputs swap with no gap.
        wr(8'h0C, 32'd0, 2'b00); wr(8'h10, 32'd0, 2'b00); wr(8'h00, 32'h2, 2'b00);
        for (int i = 0; i < 6; i++) idle({i[0], 1'b0}, 1);

        // Disable while mid-way through a rising dead interval.
        wr(8'h04, 32'd6, 2'b00); wr(8'h08, 32'd0, 2'b00); wr(8'h00, 32'h1, 2'b00);
        idle(2'b00, 3); idle(2'b01, 2);
        wr(8'h00, 32'h0, 2'b01); rd(8'h14, 2'b01); idle(2'b01, 2);

        // Inverted outputs on channel 0.
        wr(8'h08, 32'd3, 2'b00); wr(8'h00, 32'h5, 2'b00);
        idle(2'b00, 6); idle(2'b01, 9); rd(8'h14, 2'b01);

        // Asynchronous reset in the middle of a dead interval.
        idle(2'b00, 2);
        #2 rstn = 1'b0;
        #1 chk("async_reset_outputs", {28'd0, pwm_hs_o, pwm_ls_o}, 32'd0);
        m_reset();
        @(negedge clock);
        rstn = 1'b1;
        rd(8'h14, 2'b00); rd(8'h00, 2'b00);

        // Randomised traffic on both channels.
        hold[0] = 1; hold[1] = 1; p = 2'b00;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 2; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin p[c] = ~p[c]; hold[c] = $urandom_range(1, 9); end
            end
            r = $urandom_range(0, 29);
            if (r == 0)
                wr(8'h00, {28'd0, 4'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11}, p);
            else if (r <= 2)
                wr(8'(4 + 4 * $urandom_range(0, 3)), 32'($urandom_range(0, 6)), p);
            else if (r <= 5)
                rd(rd_addrs[$urandom_range(0, 8)], p);
            else if (r == 6 && $urandom_range(0, 3) == 0)
                wr(8'h18, 32'($urandom), p);
            else
                cycle(p, 0, 8'h00, 32'd0);
        end
        rd(8'h18, p); rd(8'h14, p);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_deadband.md
# pwm_deadband

Complementary-output stage placed directly downstream of the two-channel PWM generator. It takes the raw `pwm_o[1:0]` signals and drives a high-side/low-side gate pair per channel, with programmable rising and falling dead time. It also swallows pulses shorter than the dead time. Configuration uses the same APB slave port style as the PWM generator, on its own address slot.

## Interface
- `DT_W`, default 16: width of the dead-time registers and counters (1..32).

Ports:
- `clock`  in  1  system clock
- `rstn`  in  1  reset, asynchronous, active-low
- `apb_addr`  in  32  register address; only `[7:0]` decoded
- `apb_sel`  in  1  slave select
- `apb_write`  in  1  1 = write
- `apb_ena`  in  1  APB enable phase
- `apb_wdata`  in  32  write data
- `apb_rdata`  out  32  registered read data
- `apb_pstb`  in  4  strobes; ignored (full-word access only)
- `apb_rready`  out  1  tied 1
- `pwm_i`  in  2  raw PWM from the generator, same clock domain, no synchroniser
- `pwm_hs_o`  out  2  high-side drive per channel
- `pwm_ls_o`  out  2  low-side drive per channel

## Operation
Registers:
- 0x00 CTRL: `[1:0]` per-channel enable; `[3:2]` per-channel output invert.
- 0x04 DT0R: channel 0 rising dead time, `[DT_W-1:0]`.
- 0x08 DT0F: channel 0 falling dead time.
- 0x0C DT1R: channel 1 rising dead time.
- 0x10 DT1F: channel 1 falling dead time.
- 0x14 STATUS (read-only): `[2:0]` ch0 state, `[6:4]` ch1 state.
- 0x18 GLITCH: `[15:0]` ch0 swallowed-pulse count, `[31:16]` ch1 count. Any write clears both counts.

APB access:
- Write: takes effect on the edge where `apb_sel && apb_write && !apb_ena`.
- Read: on the edge where `apb_sel && !apb_write && !apb_ena`, `apb_rdata` loads the addressed register. Unmapped addresses return 0.

Per-channel FSM (encoding OFF=0, LS_ON=1, DEAD_R=2, HS_ON=3, DEAD_F=4). `cnt` is a `DT_W`-bit counter.
- Any state with enable=0 -> OFF.
- OFF, enable=1 -> DEAD_F with cnt=1. If DTxF=0, go straight to LS_ON.
- LS_ON, pwm_i=1 -> DEAD_R with cnt=1. If DTxR=0, go straight to HS_ON.
- DEAD_R:
  - pwm_i=0 -> LS_ON, and the glitch count increments.
  - else if cnt>=DTxR -> HS_ON.
  - else cnt+1.
- HS_ON, pwm_i=0 -> DEAD_F with cnt=1. If DTxF=0, go straight to LS_ON.
- DEAD_F:
  - pwm_i=1 -> HS_ON, and the glitch count increments.
  - else if cnt>=DTxF -> LS_ON.
  - else cnt+1.

Outputs (registered, derived from the next state):
- hs = (state==HS_ON) XOR inv.
- ls = (state==LS_ON) XOR inv.
- In OFF, DEAD_R and DEAD_F, both outputs are at the inactive level (`inv`).

Rules:
- The comparison is `>=`, so shrinking DTxx mid-count ends the dead time on the next edge.
- Glitch counters saturate at 0xFFFF.
- If a clear write and an increment land on the same edge, the clear wins.

## Timing
- Reset: `apb_rdata`=0, all registers 0, both FSMs OFF, `pwm_hs_o`=`pwm_ls_o`=2'b00.
- Input-to-output latency is 1 cycle: a `pwm_i` change sampled at edge t moves the outputs after edge t.
- Dead time is exactly N cycles with both outputs inactive. With dead time N: the edge at t drops the active side, and the opposite side asserts after edge t+N.
- A disable takes effect after the next edge, whatever the current state.
- Asserting `rstn` mid-count forces OFF immediately, asynchronously.
- `apb_rdata` is valid one cycle after the setup-phase edge.

## Configuration
- `PWM_DB_GLITCH_CNT_EN` defined: the GLITCH register and its counters are built as described.
- Undefined: no counters are built, 0x18 reads 0, and writes to 0x18 are ignored. FSM behaviour is unchanged.

## Test plan
- Reset check: release `rstn`, then read 0x00–0x18 -> all 0; `pwm_hs_o`=`pwm_ls_o`=0.
- CTRL=0x1, DT0R=3, DT0F=2 -> after 2 cycles `ls[0]`=1. `pwm_i[0]` 0->1 at edge t -> `ls[0]`=0 after t, `hs[0]`=1 after t+3. Fall at edge u -> `hs[0]`=0 after u, `ls[0]`=1 after u+2.
- DT0R=5, `pwm_i[0]` high for 2 cycles -> `hs[0]` never asserts and `ls[0]` returns high. GLITCH=0x0000_0001; write 0x18 -> reads 0. Without `PWM_DB_GLITCH_CNT_EN` it reads 0 throughout.
- DT1R=DT1F=0, CTRL=0x2, toggle `pwm_i[1]` -> `hs[1]`/`ls[1]` swap one cycle after each edge with no both-low gap.
- Clear CTRL while ch0 is in DEAD_R with cnt=2 -> after the next edge STATUS[2:0]=0 and both ch0 outputs are 0.
- CTRL=0x5 (ch0 enabled, inverted): in OFF/DEAD states both ch0 outputs = 1; in LS_ON, `ls[0]`=0 and `hs[0]`=1.
